l2_block_responder: RTL
=======================

// Module: l2_block_responder
// PURPOSE
// - Memory-side responder for the L2 block request interface driven by the cache arbiter.
// - Accepts level-held block read/write requests and serves them from an on-chip block array.
// - Asserts a one-cycle resp after a fixed, parameterised latency.
// - Used as the L2/pmem stand-in and as the far end for arbiter integration tests.
// PARAMETERS
// - DEPTH_BLOCKS  32  number of 128-bit blocks stored; power of two, >= 2
// - LATENCY       4   cycles from request acceptance to resp; integer >= 1
// PORTS
// - clk           in   1    single clock; all state changes on rising edge
// - rst_n         in   1    reset, asynchronous, active-low
// - pmem_read     in   1    block read request, held high until resp
// - pmem_write    in   1    block write request, held high until resp
// - pmem_address  in   16   lc3b_word byte address; [3:0] ignored
// - pmem_wdata    in   128  lc3b_block write data
// - pmem_resp     out  1    one-cycle completion pulse
// - pmem_rdata    out  128  lc3b_block read data, valid in the read resp cycle
// - busy          out  1    high in BUSY and RESP states
// - protocol_err  out  1    sticky flag: read and write seen high together
// BEHAVIOUR
// - Reset: pmem_resp=0, pmem_rdata=0, busy=0, protocol_err=0, state=IDLE, counter=0.
// - Block array is not reset; its contents are undefined until written.
// - Index is pmem_address[4+log2(DEPTH_BLOCKS)-1:4]; upper address bits alias.
// - FSM IDLE: when read|write is high, latch op, index and wdata, set counter=1, go to BUSY.
// - Accept cycle is cycle 0.
// - FSM BUSY: each cycle compare the live request to the latched one.
//   - Request dropped (read=write=0): abort to IDLE; no resp; write not committed.
//   - Op or index differs: re-latch, counter=1, stay in BUSY (restart).
//   - Otherwise counter++; when counter==LATENCY, go to RESP.
// - FSM RESP: pmem_resp=1 for exactly one cycle; go to IDLE.
//   - Read: pmem_rdata = array[index] from this cycle onward.
//   - Write: array[index] <= latched wdata at the edge ending RESP.
//   - resp is therefore high in cycle LATENCY counted from the accept cycle.
//   - The RESP cycle ignores live inputs; no compare, no abort.
// - pmem_rdata holds its last read value outside read resp cycles; writes do not alter it.
// - After RESP the FSM always returns to IDLE.
//   - A requester that drops the request in the cycle after resp gets no double service.
//   - A new request in that cycle is accepted normally (back-to-back, one idle cycle).
// - read & write both high: treated as a write; protocol_err set (sticky until rst_n).
// - wdata changes during BUSY without op/index change: ignored; wdata latched at accept/restart.
// - Read after write to the same index returns the new data (write commits before the next accept).
// - rst_n low mid-operation: immediate return to reset values; a pending write is discarded.
// TESTING
// - Write 0x0040 with 0x0123..CDEF, then read 0x0040:
//   each resp lands LATENCY=4 cycles after accept; rdata = written block.
// - Aliasing, DEPTH_BLOCKS=32: write 0x0040 block A, read 0x0240 -> rdata=A (both index 4).
// - Abort: read held 2 cycles then dropped -> no resp, busy=0 next cycle.
//   Write aborted at cycle 3 -> a later read shows the old data.
// - Restart: read 0x0010, switch address to 0x0020 at cycle 2:
//   resp at cycle 6 with the block at 0x0020; no resp for 0x0010.
// - read=write=1 at 0x0080 -> write performed, resp at cycle 4, protocol_err=1 until rst_n.
// - rst_n pulsed low at cycle 2 of a write to 0x0050:
//   outputs zero immediately, no resp, block at 0x0050 unchanged.

Source files
------------

// File: rtl/l2_block_responder.sv
// Block read/write responder: serves held requests from an on-chip block array, resp LATENCY cycles after accept.
// Latency LATENCY cycles from accept to the one-cycle resp; requests are level-held, and dropping one mid-flight aborts it.
module l2_block_responder #(
  parameter int DEPTH_BLOCKS = 32,
  parameter int LATENCY      = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         pmem_read,
  input  logic         pmem_write,
  input  logic [15:0]  pmem_address,
  input  logic [127:0] pmem_wdata,
  output logic         pmem_resp,
  output logic [127:0] pmem_rdata,
  output logic         busy,
  output logic         protocol_err
);

  localparam int IW = $clog2(DEPTH_BLOCKS);
  localparam int CW = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            lat_wr;
  logic [IW-1:0]   lat_idx;
  logic [127:0]    lat_wdata;
  logic [127:0]    mem [DEPTH_BLOCKS];

  logic            req;
  logic [IW-1:0]   live_idx;
  logic            unused_addr;

  assign req         = pmem_read | pmem_write;
  assign live_idx    = pmem_address[4 +: IW];
  assign unused_addr = ^{pmem_address[15:4+IW], pmem_address[3:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      pmem_resp    <= 1'b0;
      pmem_rdata   <= '0;
      busy         <= 1'b0;
      protocol_err <= 1'b0;
      lat_wr       <= 1'b0;
      lat_idx      <= '0;
      lat_wdata    <= '0;
    end else begin
      pmem_resp <= 1'b0;
      if (pmem_read && pmem_write) protocol_err <= 1'b1;
      case (state)
        IDLE: begin
          if (req) begin
            lat_wr    <= pmem_write;
            lat_idx   <= live_idx;
            lat_wdata <= pmem_wdata;
            cnt       <= CW'(1);
            busy      <= 1'b1;
            if (LATENCY == 1) begin
              state     <= RESP;
              pmem_resp <= 1'b1;
              if (!pmem_write) pmem_rdata <= mem[live_idx];
            end else begin
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          if (!req) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
          end else if (pmem_write != lat_wr || live_idx != lat_idx) begin
            lat_wr    <= pmem_write;
            lat_idx   <= live_idx;
            lat_wdata <= pmem_wdata;
            cnt       <= CW'(1);
          end else if (cnt + CW'(1) == CW'(LATENCY)) begin
            // Live request matches the latched one here, so live index/op are safe to use.
            state     <= RESP;
            pmem_resp <= 1'b1;
            if (!pmem_write) pmem_rdata <= mem[live_idx];
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Array is intentionally unreset; a write commits only at the edge leaving RESP.
  always_ff @(posedge clk) begin
    if (state == RESP && lat_wr) mem[lat_idx] <= lat_wdata;
  end

endmodule
